// File: rtl/stream_demux2.sv
// One-input, two-output stream demultiplexer. Each output port has its own
// 2-entry FIFO, so a stalled port never blocks traffic headed for the other.
module stream_demux2 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_a_data,
    output logic         out_a_valid,
    input  logic         out_a_ready,
    output logic [N-1:0] out_b_data,
    output logic         out_b_valid,
    input  logic         out_b_ready,
    output logic         busy
);

    // Index 0 is port A, index 1 is port B. head is the entry on the output.
    logic [N-1:0] head_q  [2];
    logic [N-1:0] head_d  [2];
    logic [N-1:0] tail_q  [2];
    logic [N-1:0] tail_d  [2];
    logic [1:0]   count_q [2];
    logic [1:0]   count_d [2];
    logic         in_ready_s;
    logic [1:0]   push_s;
    logic [1:0]   pop_s;

    // Input acceptance looks only at the selected port's occupancy, never at downstream ready.
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (in_sel) begin
            in_ready_s = (count_q[1] < 2'd2);
        end else begin
            in_ready_s = (count_q[0] < 2'd2);
        end
        push_s[0] = in_valid & in_ready_s & ~in_sel;
        push_s[1] = in_valid & in_ready_s & in_sel;
        pop_s[0]  = (count_q[0] != 2'd0) & out_a_ready;
        pop_s[1]  = (count_q[1] != 2'd0) & out_b_ready;
    end

    // Per-port FIFO next state; a push at count 2 cannot occur because in_ready is low.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            head_d[p]  = head_q[p];
            tail_d[p]  = tail_q[p];
            count_d[p] = count_q[p];
            case ({push_s[p], pop_s[p]})
                2'b10: begin
                    if (count_q[p] == 2'd0) begin
                        head_d[p] = in_data;
                    end else begin
                        tail_d[p] = in_data;
                    end
                    count_d[p] = count_q[p] + 2'd1;
                end
                2'b01: begin
                    head_d[p]  = tail_q[p];
                    count_d[p] = count_q[p] - 2'd1;
                end
                2'b11: begin
                    if (count_q[p] == 2'd2) begin
                        head_d[p] = tail_q[p];
                        tail_d[p] = in_data;
                    end else begin
                        head_d[p] = in_data;
                    end
                end
                default: begin
                    count_d[p] = count_q[p];
                end
            endcase
        end
    end

    // FIFO state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                head_q[p]  <= '0;
                tail_q[p]  <= '0;
                count_q[p] <= 2'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                head_q[p]  <= head_d[p];
                tail_q[p]  <= tail_d[p];
                count_q[p] <= count_d[p];
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_a_data  = head_q[0];
    assign out_a_valid = (count_q[0] != 2'd0);
    assign out_b_data  = head_q[1];
    assign out_b_valid = (count_q[1] != 2'd0);
    assign busy        = (count_q[0] != 2'd0) | (count_q[1] != 2'd0);

endmodule

// File: tb/tb_stream_demux2.sv
// Directed, table-driven bench for stream_demux2: one record per clock cycle,
// plus a hand-written back-to-back streaming sequence on port B.
module tb_stream_demux2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_a_data;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [31:0] out_b_data;
    logic        out_b_valid;
    logic        out_b_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_demux2 #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_a_data (out_a_data),
        .out_a_valid(out_a_valid),
        .out_a_ready(out_a_ready),
        .out_b_data (out_b_data),
        .out_b_valid(out_b_valid),
        .out_b_ready(out_b_ready),
        .busy       (busy)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        e_rdy;
        logic        e_av;
        logic [31:0] e_ad;
        logic        e_bv;
        logic [31:0] e_bd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic sel, input logic [31:0] d,
                       input logic ar, input logic br, input logic e_rdy,
                       input logic e_av, input logic [31:0] e_ad,
                       input logic e_bv, input logic [31:0] e_bd, input logic e_busy);
        vec_t x;
        x.rst = r; x.v = v; x.sel = sel; x.d = d; x.ar = ar; x.br = br;
        x.e_rdy = e_rdy; x.e_av = e_av; x.e_ad = e_ad;
        x.e_bv = e_bv; x.e_bd = e_bd; x.e_busy = e_busy;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'h0;
        out_a_ready = 1'b0; out_b_ready = 1'b0;

        //   rst   v     sel   data          ar    br    rdy   av    ad            bv    bd            busy
        // reset held two cycles with a beat presented
        add(1'b1, 1'b1, 1'b0, 32'h0000DEAD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        add(1'b1, 1'b1, 1'b0, 32'h0000DEAD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        // routing
        add(1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        // backpressure on A, third beat refused
        add(1'b0, 1'b1, 1'b0, 32'h000000A0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000A0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h000000A1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000A0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h000000A2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000000A0, 1'b0, 32'h0,        1'b1);
        // isolation: B passes while A is full and stalled
        add(1'b0, 1'b1, 1'b1, 32'h000000B5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000A0, 1'b1, 32'h000000B5, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000A0, 1'b0, 32'h0,        1'b1);
        // release A; full port refuses, then push+pop at count 1 makes new beat the head
        add(1'b0, 1'b1, 1'b0, 32'h000000A2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000A1, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h000000A2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000A2, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        // mid-operation reset with A=2, B=1 buffered
        add(1'b0, 1'b1, 1'b0, 32'h000000C0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000C0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h000000C1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000C0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h000000C2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000C0, 1'b1, 32'h000000C2, 1'b1);
        add(1'b1, 1'b1, 1'b1, 32'h000000C3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        // first transfer right after reset
        add(1'b0, 1'b1, 1'b1, 32'h000000D0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h000000D0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].v; in_sel = vecs[i].sel; in_data = vecs[i].d;
            out_a_ready = vecs[i].ar; out_b_ready = vecs[i].br;
            #1;
            check("in_ready", i, {31'b0, in_ready}, {31'b0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check("out_a_valid", i, {31'b0, out_a_valid}, {31'b0, vecs[i].e_av});
            check("out_b_valid", i, {31'b0, out_b_valid}, {31'b0, vecs[i].e_bv});
            check("busy", i, {31'b0, busy}, {31'b0, vecs[i].e_busy});
            if (vecs[i].e_av || vecs[i].rst) begin
                check("out_a_data", i, out_a_data, vecs[i].e_ad);
            end
            if (vecs[i].e_bv || vecs[i].rst) begin
                check("out_b_data", i, out_b_data, vecs[i].e_bd);
            end
        end

        // 16 back-to-back beats to B with ready held high, A idle
        out_a_ready = 1'b1; out_b_ready = 1'b1; rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hE000_0000 + 32'(i);
            #1;
            check("stream_in_ready", 100 + i, {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check("stream_b_valid", 100 + i, {31'b0, out_b_valid}, 32'd1);
            check("stream_b_data", 100 + i, out_b_data, 32'hE000_0000 + 32'(i));
            check("stream_a_valid", 100 + i, {31'b0, out_a_valid}, 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_drain_b_valid", 200, {31'b0, out_b_valid}, 32'd0);
        check("stream_drain_busy", 200, {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
